fetch_decode_ctrl: RTL and testbench

- Control unit at the consuming end of the fetch path: program counter → ROM → 8-bit fetch register.
- Alternates FETCH and EXEC phases and drives the fetch register enable (enF) and the program counter controls (enP, load, load_1).
- Decodes the latched instr/operand nibbles into datapath controls for the ALU, accumulator, flags, RAM and output port.
- Handles two-byte jump instructions by reading the address byte directly from progbyte.

---
 rtl/fetch_decode_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_decode_ctrl
//
// Control unit that sits at the consuming end of the fetch path
// (program counter -> ROM -> 8-bit fetch register). It alternates between a
// FETCH phase and an EXEC phase. In FETCH it latches the ROM byte into the
// fetch register and advances the PC. In EXEC it decodes the latched
// instr/operand nibbles into datapath controls. Two-byte jumps take their low
// address byte straight from the ROM output (progbyte) during EXEC.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   instr        opcode nibble from the fetch register
//   operand      operand nibble from the fetch register
//   progbyte     current ROM output (byte at PC)
//   c_flag       registered carry flag
//   z_flag       registered zero flag
//   enF          fetch register enable
//   enP          PC increment enable
//   load         PC load enable
//   load_1       PC load value (12 bits)
//   alu_sel      000 PASS_B, 001 ADD, 010 SUB, 011 AND, 100 OR
//   oe_oprnd     drive operand onto the ALU B bus
//   loadA        accumulator load
//   loadFlags    flag register load
//   cs_ram       RAM chip select (RAM address is operand)
//   we_ram       RAM write, only together with cs_ram
//   oe_alu       drive accumulator onto the data bus
//   out_load     output-port load pulse
//   phase        0 = FETCH, 1 = EXEC or HALT
//   halted       high in the HALT state
//   retire_count instructions executed, wraps
// ---------------------------------------------------------------------------
module fetch_decode_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       instr,
   input  logic [3:0]       operand,
   input  logic [7:0]       progbyte,
   input  logic             c_flag,
   input  logic             z_flag,
   output logic             enF,
   output logic             enP,
   output logic             load,
   output logic [11:0]      load_1,
   output logic [2:0]       alu_sel,
   output logic             oe_oprnd,
   output logic             loadA,
   output logic             loadFlags,
   output logic             cs_ram,
   output logic             we_ram,
   output logic             oe_alu,
   output logic             out_load,
   output logic             phase,
   output logic             halted,
   output logic [CNT_W-1:0] retire_count
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t state;
   state_t nxt;
   logic   taken;

   // Jump condition for opcodes 0..4; the other opcodes never look at it.
   assign taken = (instr == 4'h0) ?  c_flag :
                  (instr == 4'h1) ? ~c_flag :
                  (instr == 4'h2) ?  z_flag :
                  (instr == 4'h3) ? ~z_flag :
                  (instr == 4'h4);

   // State register and retired-instruction counter. Every instruction
   // retires on the edge that leaves EXEC, including HALT itself, so the
   // counter stays frozen once the machine sits in HALT.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= FETCH;
         retire_count <= '0;
      end else begin
         state <= nxt;
         if (state == EXEC)
            retire_count <= retire_count + CNT_W'(1);
      end
   end

   // Next-state logic: FETCH always hands over to EXEC, EXEC returns to
   // FETCH unless it just executed HALT, and HALT only leaves via reset.
   always_comb begin
      nxt = FETCH;
      case (state)
         FETCH:   nxt = EXEC;
         EXEC:    nxt = (instr == 4'hF) ? HALT : FETCH;
         HALT:    nxt = HALT;
         default: nxt = FETCH;
      endcase
   end

   // Output decode. Everything defaults to 0, and reset keeps it that way so
   // an instruction caught mid-EXEC by reset never writes RAM or moves the PC.
   // A jump either loads the PC or bumps it past the address byte, never both.
   always_comb begin
      enF       = 1'b0;
      enP       = 1'b0;
      load      = 1'b0;
      load_1    = 12'h000;
      alu_sel   = 3'b000;
      oe_oprnd  = 1'b0;
      loadA     = 1'b0;
      loadFlags = 1'b0;
      cs_ram    = 1'b0;
      we_ram    = 1'b0;
      oe_alu    = 1'b0;
      out_load  = 1'b0;
      phase     = 1'b0;
      halted    = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               enF = 1'b1;
               enP = 1'b1;
            end
            EXEC: begin
               phase = 1'b1;
               case (instr)
                  4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                     if (taken) begin
                        load   = 1'b1;
                        load_1 = {operand, progbyte};
                     end else begin
                        enP = 1'b1;
                     end
                  end
                  4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                     alu_sel   = (instr == 4'h5) ? 3'b000 :
                                 (instr == 4'h6) ? 3'b001 :
                                 (instr == 4'h7) ? 3'b010 :
                                 (instr == 4'h8) ? 3'b011 : 3'b100;
                     oe_oprnd  = 1'b1;
                     loadA     = 1'b1;
                     loadFlags = 1'b1;
                  end
                  4'hA: begin
                     alu_sel   = 3'b010;
                     oe_oprnd  = 1'b1;
                     loadFlags = 1'b1;
                  end
                  4'hB: begin
                     cs_ram    = 1'b1;
                     loadA     = 1'b1;
                     loadFlags = 1'b1;
                  end
                  4'hC: begin
                     cs_ram = 1'b1;
                     we_ram = 1'b1;
                     oe_alu = 1'b1;
                  end
                  4'hD: begin
                     oe_alu   = 1'b1;
                     out_load = 1'b1;
                  end
                  default: ;
               endcase
            end
            HALT: begin
               phase  = 1'b1;
               halted = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_ctrl
//
// Directed bench for fetch_decode_ctrl. Each stimulus cycle drives the
// fetch-register nibbles, ROM byte and flags, and pushes the hand-computed
// control word for that cycle into a scoreboard queue. A monitor on the
// falling edge pops one entry per cycle and compares it with the DUT.
// The counter width is kept small so the wrap can be reached quickly.
// ---------------------------------------------------------------------------
module tb_fetch_decode_ctrl;

   localparam int CNT_W = 5;

   // Control word layout: {enF, enP, load, load_1[11:0], alu_sel[2:0],
   // oe_oprnd, loadA, loadFlags, cs_ram, we_ram, oe_alu, out_load, phase, halted}
   localparam logic [26:0] FULL = 27'h7FFFFFF;
   localparam logic [26:0] NOL1 = 27'h7000FFF;

   typedef struct {
      logic [26:0]      ctl;
      logic [26:0]      mask;
      logic [CNT_W-1:0] cnt;
      string            name;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [3:0]       instr = 4'h0;
   logic [3:0]       operand = 4'h0;
   logic [7:0]       progbyte = 8'h00;
   logic             c_flag = 1'b0;
   logic             z_flag = 1'b0;
   logic             enF, enP, load, oe_oprnd, loadA, loadFlags;
   logic             cs_ram, we_ram, oe_alu, out_load, phase, halted;
   logic [11:0]      load_1;
   logic [2:0]       alu_sel;
   logic [CNT_W-1:0] retire_count;
   logic [26:0]      actW;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   fetch_decode_ctrl #(.CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .instr(instr), .operand(operand),
      .progbyte(progbyte), .c_flag(c_flag), .z_flag(z_flag),
      .enF(enF), .enP(enP), .load(load), .load_1(load_1), .alu_sel(alu_sel),
      .oe_oprnd(oe_oprnd), .loadA(loadA), .loadFlags(loadFlags),
      .cs_ram(cs_ram), .we_ram(we_ram), .oe_alu(oe_alu), .out_load(out_load),
      .phase(phase), .halted(halted), .retire_count(retire_count)
   );

   assign actW = {enF, enP, load, load_1, alu_sel, oe_oprnd, loadA, loadFlags,
                  cs_ram, we_ram, oe_alu, out_load, phase, halted};

   always #5 clock = ~clock;

   // Build a control word from individually written expected fields.
   function automatic logic [26:0] ctl(input logic f, p, ld, input logic [11:0] l1,
                                       input logic [2:0] al, input logic oo, la, lf,
                                       cs, we, oa, ol, ph, h);
      return {f, p, ld, l1, al, oo, la, lf, cs, we, oa, ol, ph, h};
   endfunction

   // Drive one cycle of inputs just after the rising edge and queue what the
   // DUT should present during that cycle.
   task automatic applyStimulus(input logic rst, input logic [3:0] ins, op,
                                input logic [7:0] pb, input logic c, z,
                                input logic [26:0] e, m, input int cnt,
                                input string nm);
      exp_t x;
      @(posedge clock);
      #1;
      reset    = rst;
      instr    = ins;
      operand  = op;
      progbyte = pb;
      c_flag   = c;
      z_flag   = z;
      x.ctl    = e;
      x.mask   = m;
      x.cnt    = CNT_W'(cnt);
      x.name   = nm;
      q.push_back(x);
   endtask

   task automatic checkOutput(input exp_t x);
      checks++;
      if (((actW & x.mask) !== (x.ctl & x.mask)) || (retire_count !== x.cnt)) begin
         errors++;
         $display("[TB] FAIL %s: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d (mask %h)",
                  x.name, actW, retire_count, x.ctl, x.cnt, x.mask);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
   always @(negedge clock) begin
      if (q.size() > 0)
         checkOutput(q.pop_front());
   end

   initial begin
      logic [26:0] fw, zw;
      fw = ctl(1,1,0,12'h000,3'b000,0,0,0,0,0,0,0,0,0);
      zw = 27'h0;

      // Reset held three cycles: everything low, counter cleared.
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 4'h4, 4'hA, 8'h3C, 1, 1, zw, FULL, 0, "reset");

      // LIT 3 then ADDI 2.
      applyStimulus(0, 4'h0, 4'h0, 8'h53, 0, 0, fw, FULL, 0, "fetch1");
      applyStimulus(0, 4'h5, 4'h3, 8'h62, 0, 0, ctl(0,0,0,0,3'b000,1,1,1,0,0,0,0,1,0), FULL, 0, "lit");
      applyStimulus(0, 4'h5, 4'h3, 8'h62, 0, 0, fw, FULL, 1, "fetch2");
      applyStimulus(0, 4'h6, 4'h2, 8'h40, 0, 0, ctl(0,0,0,0,3'b001,1,1,1,0,0,0,0,1,0), FULL, 1, "addi");
      applyStimulus(0, 4'h6, 4'h2, 8'h4A, 0, 0, fw, FULL, 2, "fetch3");

      // Jumps, taken and not taken.
      applyStimulus(0, 4'h4, 4'hA, 8'h3C, 0, 0, ctl(0,0,1,12'hA3C,0,0,0,0,0,0,0,0,1,0), FULL, 2, "jmp");
      applyStimulus(0, 4'h4, 4'hA, 8'h3C, 0, 0, fw, FULL, 3, "fetch_after_jmp");
      applyStimulus(0, 4'h0, 4'h1, 8'h55, 0, 1, ctl(0,1,0,0,0,0,0,0,0,0,0,0,1,0), NOL1, 3, "jc_not_taken");
      applyStimulus(0, 4'h0, 4'h1, 8'h55, 0, 1, fw, FULL, 4, "fetch5");
      applyStimulus(0, 4'h0, 4'h1, 8'h55, 1, 0, ctl(0,0,1,12'h155,0,0,0,0,0,0,0,0,1,0), FULL, 4, "jc_taken");
      applyStimulus(0, 4'h0, 4'h1, 8'h55, 1, 0, fw, FULL, 5, "fetch6");
      applyStimulus(0, 4'h2, 4'h0, 8'h10, 0, 1, ctl(0,0,1,12'h010,0,0,0,0,0,0,0,0,1,0), FULL, 5, "jz_taken");
      applyStimulus(0, 4'h2, 4'h0, 8'h10, 0, 1, fw, FULL, 6, "fetch7");
      applyStimulus(0, 4'h3, 4'h6, 8'h77, 0, 1, ctl(0,1,0,0,0,0,0,0,0,0,0,0,1,0), NOL1, 6, "jnz_not_taken");
      applyStimulus(0, 4'h3, 4'h6, 8'h77, 0, 1, fw, FULL, 7, "fetch8");
      applyStimulus(0, 4'h1, 4'hF, 8'hFF, 0, 0, ctl(0,0,1,12'hFFF,0,0,0,0,0,0,0,0,1,0), FULL, 7, "jnc_taken");
      applyStimulus(0, 4'h1, 4'hF, 8'hFF, 0, 0, fw, FULL, 8, "fetch9");

      // ALU, RAM and output-port opcodes.
      applyStimulus(0, 4'hA, 4'h5, 8'h00, 0, 0, ctl(0,0,0,0,3'b010,1,0,1,0,0,0,0,1,0), FULL, 8, "cmpi");
      applyStimulus(0, 4'hA, 4'h5, 8'h00, 0, 0, fw, FULL, 9, "fetch10");
      applyStimulus(0, 4'h7, 4'h1, 8'h00, 0, 0, ctl(0,0,0,0,3'b010,1,1,1,0,0,0,0,1,0), FULL, 9, "subi");
      applyStimulus(0, 4'h7, 4'h1, 8'h00, 0, 0, fw, FULL, 10, "fetch11");
      applyStimulus(0, 4'h8, 4'hC, 8'h00, 0, 0, ctl(0,0,0,0,3'b011,1,1,1,0,0,0,0,1,0), FULL, 10, "andi");
      applyStimulus(0, 4'h8, 4'hC, 8'h00, 0, 0, fw, FULL, 11, "fetch12");
      applyStimulus(0, 4'h9, 4'h3, 8'h00, 0, 0, ctl(0,0,0,0,3'b100,1,1,1,0,0,0,0,1,0), FULL, 11, "ori");
      applyStimulus(0, 4'h9, 4'h3, 8'h00, 0, 0, fw, FULL, 12, "fetch13");
      applyStimulus(0, 4'hB, 4'h4, 8'h00, 0, 0, ctl(0,0,0,0,3'b000,0,1,1,1,0,0,0,1,0), FULL, 12, "ld");
      applyStimulus(0, 4'hB, 4'h4, 8'h00, 0, 0, fw, FULL, 13, "fetch14");
      applyStimulus(0, 4'hD, 4'h0, 8'h00, 0, 0, ctl(0,0,0,0,3'b000,0,0,0,0,0,1,1,1,0), FULL, 13, "out");
      applyStimulus(0, 4'hD, 4'h0, 8'h00, 0, 0, fw, FULL, 14, "fetch15");
      applyStimulus(0, 4'hE, 4'h9, 8'h00, 1, 1, ctl(0,0,0,0,0,0,0,0,0,0,0,0,1,0), FULL, 14, "nop");
      applyStimulus(0, 4'hE, 4'h9, 8'h00, 0, 0, fw, FULL, 15, "fetch16");
      applyStimulus(0, 4'hC, 4'h7, 8'h00, 0, 0, ctl(0,0,0,0,0,0,0,0,1,1,1,0,1,0), FULL, 15, "st");
      applyStimulus(0, 4'hC, 4'h7, 8'h00, 0, 0, fw, FULL, 16, "fetch17");

      // Second ST abandoned by reset during its EXEC.
      applyStimulus(1, 4'hC, 4'h7, 8'h00, 0, 0, zw, FULL, 16, "st_reset");
      applyStimulus(0, 4'hC, 4'h7, 8'hF0, 0, 0, fw, FULL, 0, "fetch_after_reset");

      // HALT, then ten idle cycles with hostile inputs.
      applyStimulus(0, 4'hF, 4'h0, 8'h00, 0, 0, ctl(0,0,0,0,0,0,0,0,0,0,0,0,1,0), FULL, 0, "halt_exec");
      for (int i = 0; i < 10; i++)
         applyStimulus(0, 4'(i % 5), 4'hA, 8'h3C, 1, 0,
                       ctl(0,0,0,0,0,0,0,0,0,0,0,0,1,1), FULL, 1, "halted");
      applyStimulus(1, 4'h0, 4'h0, 8'h00, 0, 0, zw, FULL, 1, "reset_from_halt");

      // 32 NOPs wrap the 5-bit counter back to zero.
      for (int k = 0; k < 32; k++) begin
         applyStimulus(0, 4'hE, 4'h0, 8'hE0, 0, 0, fw, FULL, k, "wrap_fetch");
         applyStimulus(0, 4'hE, 4'h0, 8'hE0, 0, 0,
                       ctl(0,0,0,0,0,0,0,0,0,0,0,0,1,0), FULL, k, "wrap_exec");
      end
      applyStimulus(0, 4'hE, 4'h0, 8'h00, 0, 0, fw, FULL, 0, "wrapped");

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 5 && q.size() > 0; i++)
         @(posedge clock);
      if (q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
